// File: rtl/tia_hsync_counter.sv
// Horizontal sync counter: color clock / 4 steps a period-57 polynomial counter (228-clock line).
// Strobes and levels are registered on the edge that enters each count; no backpressure.
module tia_hsync_counter #(
   parameter int LINE_COUNTS = 57,
   parameter int SHS_COUNT   = 4,
   parameter int RHS_COUNT   = 8,
   parameter int RCB_COUNT   = 12,
   parameter int RHB_COUNT   = 16,
   parameter int LRHB_COUNT  = 18,
   parameter int CNT_COUNT   = 36
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rsync_strobe,
   input  logic       hmove_strobe,
   output logic [5:0] lfsr,
   output logic       phi1,
   output logic       phi2,
   output logic       shb_pulse,
   output logic       rhb_pulse,
   output logic       center_pulse,
   output logic       hsync,
   output logic       hblank,
   output logic       cburst
);

   // Maps a count index to the polynomial state reached after that many advances.
   function automatic logic [5:0] lfsr_at(input int k);
      logic [5:0] s;
      s = 6'b000000;
      for (int i = 0; i < k; i++) begin
         s = {s[4:0], ~(s[5] ^ s[4])};
      end
      return s;
   endfunction

   localparam logic [5:0] ST_ZERO = 6'b000000;
   localparam logic [5:0] ST_LOCK = 6'b111111;
   localparam logic [5:0] ST_LAST = lfsr_at(LINE_COUNTS - 1);
   localparam logic [5:0] ST_SHS  = lfsr_at(SHS_COUNT);
   localparam logic [5:0] ST_RHS  = lfsr_at(RHS_COUNT);
   localparam logic [5:0] ST_RCB  = lfsr_at(RCB_COUNT);
   localparam logic [5:0] ST_RHB  = lfsr_at(RHB_COUNT);
   localparam logic [5:0] ST_LRHB = lfsr_at(LRHB_COUNT);
   localparam logic [5:0] ST_CNT  = lfsr_at(CNT_COUNT);

   logic [1:0] div;
   logic       hmove_latch;
   logic       advance;
   logic       wrap;
   logic [5:0] lfsr_nxt;
   logic       hit_shb;
   logic       hit_rhb;
   logic       hit_cnt;
   logic       hit_shs;
   logic       hit_rhs;
   logic       hit_rcb;

   always_comb begin
      advance  = (div == 2'd3);
      wrap     = (lfsr == ST_LAST) || (lfsr == ST_LOCK);
      lfsr_nxt = wrap ? ST_ZERO : {lfsr[4:0], ~(lfsr[5] ^ lfsr[4])};
      phi1     = (div == 2'd0);
      phi2     = (div == 2'd2);
      hit_shb  = advance && (lfsr_nxt == ST_ZERO);
      // Late reset fires only if the normal one was skipped, i.e. hblank is still up.
      hit_rhb  = advance && (((lfsr_nxt == ST_RHB) && !hmove_latch) ||
                             ((lfsr_nxt == ST_LRHB) && hblank));
      hit_cnt  = advance && (lfsr_nxt == ST_CNT);
      hit_shs  = advance && (lfsr_nxt == ST_SHS);
      hit_rhs  = advance && (lfsr_nxt == ST_RHS);
      hit_rcb  = advance && (lfsr_nxt == ST_RCB);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         div          <= 2'd0;
         lfsr         <= ST_ZERO;
         hmove_latch  <= 1'b0;
         shb_pulse    <= 1'b0;
         rhb_pulse    <= 1'b0;
         center_pulse <= 1'b0;
         hsync        <= 1'b0;
         hblank       <= 1'b1;
         cburst       <= 1'b0;
      end else if (rsync_strobe) begin
         div          <= 2'd0;
         lfsr         <= ST_ZERO;
         hmove_latch  <= 1'b0;
         shb_pulse    <= 1'b1;
         rhb_pulse    <= 1'b0;
         center_pulse <= 1'b0;
         hsync        <= 1'b0;
         hblank       <= 1'b1;
         cburst       <= 1'b0;
      end else begin
         div          <= div + 2'd1;
         shb_pulse    <= hit_shb;
         rhb_pulse    <= hit_rhb;
         center_pulse <= hit_cnt;
         if (advance) begin
            lfsr <= lfsr_nxt;
         end
         // A strobe on the line-start edge is kept for the new line.
         if (hmove_strobe) begin
            hmove_latch <= 1'b1;
         end else if (hit_shb) begin
            hmove_latch <= 1'b0;
         end
         if (hit_shb) begin
            hblank <= 1'b1;
         end else if (hit_rhb) begin
            hblank <= 1'b0;
         end
         if (hit_shs) begin
            hsync <= 1'b1;
         end else if (hit_rhs) begin
            hsync <= 1'b0;
         end
         if (hit_rhs) begin
            cburst <= 1'b1;
         end else if (hit_rcb) begin
            cburst <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_tia_hsync_counter.sv
// Bench for tia_hsync_counter: line-time reference model feeding a scoreboard, plus fixed checkpoints.
module tb_tia_hsync_counter;

   logic       clock = 1'b0;
   logic       reset;
   logic       rsync_strobe;
   logic       hmove_strobe;
   logic [5:0] lfsr;
   logic       phi1, phi2, shb_pulse, rhb_pulse, center_pulse, hsync, hblank, cburst;

   tia_hsync_counter dut (
      .clock        (clock),
      .reset        (reset),
      .rsync_strobe (rsync_strobe),
      .hmove_strobe (hmove_strobe),
      .lfsr         (lfsr),
      .phi1         (phi1),
      .phi2         (phi2),
      .shb_pulse    (shb_pulse),
      .rhb_pulse    (rhb_pulse),
      .center_pulse (center_pulse),
      .hsync        (hsync),
      .hblank       (hblank),
      .cburst       (cburst)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [5:0] lfsr;
      logic       phi1;
      logic       phi2;
      logic       shb;
      logic       rhb;
      logic       center;
      logic       hsync;
      logic       hblank;
      logic       cburst;
   } obs_t;

   // Checkpoint: clock since reset release, lfsr (-1 = not checked), {shb,rhb,center,hsync,hblank,cburst}.
   typedef struct {
      int         clk;
      int         lfsr;
      logic [5:0] lv;
   } chk_t;

   typedef struct {
      string name;
      int    clocks;
      int    hm_at;
      int    rs_at;
      bit    use_tab;
   } scen_t;

   localparam int N_CHK  = 19;
   localparam int N_SCEN = 5;
   localparam obs_t RST_EXP = {6'b000000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

   chk_t       chk_tab [N_CHK];
   scen_t      scen_tab[N_SCEN];
   logic [5:0] lfsr_tab[57];
   obs_t       sb_q[$];
   int         n_vec = 0;
   int         n_bad = 0;

   // Reference model state: line time, HMOVE latch, extension chosen for this line, post-reset flag.
   int t;
   bit lm;
   bit ext;
   bit fresh;

   function automatic obs_t sample();
      return {lfsr, phi1, phi2, shb_pulse, rhb_pulse, center_pulse, hsync, hblank, cburst};
   endfunction

   function automatic obs_t model_out();
      obs_t e;
      int   rhb_t;
      rhb_t    = ext ? 72 : 64;
      e.lfsr   = lfsr_tab[t / 4];
      e.phi1   = (t % 4 == 0);
      e.phi2   = (t % 4 == 2);
      e.shb    = (t == 0) && !fresh;
      e.rhb    = (t == rhb_t);
      e.center = (t == 144);
      e.hsync  = (t >= 16) && (t < 32);
      e.hblank = (t < rhb_t);
      e.cburst = (t >= 32) && (t < 48);
      return e;
   endfunction

   task automatic model_edge(input bit rs, input bit hm);
      fresh = 1'b0;
      if (rs) begin
         t   = 0;
         lm  = 1'b0;
         ext = 1'b0;
      end else begin
         t = (t + 1) % 228;
         if (t == 0) ext = 1'b0;
         if (t == 64) ext = lm;
         if (hm) lm = 1'b1;
         else if (t == 0) lm = 1'b0;
      end
   endtask

   task automatic check(input string name, input int c, input obs_t got, input obs_t exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s clk %0d: got %b required %b (lfsr,phi1,phi2,shb,rhb,center,hsync,hblank,cburst)",
                  name, c, got, exp);
      end
   endtask

   task automatic check_point(input chk_t ck, input obs_t got);
      obs_t exp;
      obs_t g;
      g        = got;
      exp.lfsr = (ck.lfsr < 0) ? 6'b000000 : 6'(ck.lfsr);
      if (ck.lfsr < 0) g.lfsr = 6'b000000;
      exp.phi1 = (ck.clk % 4 == 0);
      exp.phi2 = (ck.clk % 4 == 2);
      {exp.shb, exp.rhb, exp.center, exp.hsync, exp.hblank, exp.cburst} = ck.lv;
      check("checkpoint", ck.clk, g, exp);
   endtask

   task automatic apply_reset();
      reset        = 1'b0;
      rsync_strobe = 1'b0;
      hmove_strobe = 1'b0;
      sb_q.delete();
      repeat (2) @(negedge clock);
      #1;
      check("reset_hold", 0, sample(), RST_EXP);
      @(negedge clock);
      reset = 1'b1;
      t     = 0;
      lm    = 1'b0;
      ext   = 1'b0;
      fresh = 1'b1;
      sb_q.push_back(model_out());
   endtask

   // Entered just after a falling edge; clock c is compared, then its strobes are driven.
   task automatic run_clocks(input string name, input int n, input int hm_at, input int rs_at,
                             input bit use_tab);
      obs_t got;
      obs_t exp;
      for (int c = 0; c <= n; c++) begin
         #1;
         got = sample();
         if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s clk %0d: scoreboard empty, got %b", name, c, got);
         end else begin
            exp = sb_q.pop_front();
            check(name, c, got, exp);
         end
         if (use_tab) begin
            for (int i = 0; i < N_CHK; i++) begin
               if (chk_tab[i].clk == c) check_point(chk_tab[i], got);
            end
         end
         if (c < n) begin
            hmove_strobe = (c == hm_at);
            rsync_strobe = (c == rs_at);
            @(posedge clock);
            model_edge(rsync_strobe, hmove_strobe);
            sb_q.push_back(model_out());
            @(negedge clock);
         end
      end
      hmove_strobe = 1'b0;
      rsync_strobe = 1'b0;
   endtask

   initial begin
      logic [5:0] s;
      s = 6'b000000;
      for (int k = 0; k < 57; k++) begin
         lfsr_tab[k] = s;
         s = {s[4:0], ~(s[5] ^ s[4])};
      end

      chk_tab = '{
         '{0,   0,  6'b000010}, '{1,   0,  6'b000010}, '{4,   1,  6'b000010},
         '{8,   3,  6'b000010}, '{16,  15, 6'b000110}, '{20,  31, 6'b000110},
         '{24,  62, 6'b000110}, '{31,  61, 6'b000110}, '{32,  59, 6'b000011},
         '{47,  -1, 6'b000011}, '{48,  -1, 6'b000010}, '{63,  -1, 6'b000010},
         '{64,  -1, 6'b010000}, '{65,  -1, 6'b000000}, '{144, -1, 6'b001000},
         '{145, -1, 6'b000000}, '{227, -1, 6'b000000}, '{228, 0,  6'b100010},
         '{229, 0,  6'b000010}
      };

      scen_tab = '{
         '{"free_run",    460, -1,  -1,  1'b1},
         '{"hmove_20",    460, 20,  -1,  1'b0},
         '{"hmove_at_64", 460, 63,  -1,  1'b0},
         '{"rsync_100",   331, 100, 100, 1'b0},
         '{"hmove_rsync", 300, 30,  50,  1'b0}
      };

      for (int i = 0; i < N_SCEN; i++) begin
         apply_reset();
         run_clocks(scen_tab[i].name, scen_tab[i].clocks, scen_tab[i].hm_at,
                    scen_tab[i].rs_at, scen_tab[i].use_tab);
      end

      // Reset dropped mid-hsync must take effect without waiting for a clock edge.
      apply_reset();
      run_clocks("pre_reset", 20, -1, -1, 1'b0);
      reset = 1'b0;
      #1;
      check("async_reset", 20, sample(), RST_EXP);
      sb_q.delete();
      @(negedge clock);
      reset = 1'b1;
      t     = 0;
      lm    = 1'b0;
      ext   = 1'b0;
      fresh = 1'b1;
      sb_q.push_back(model_out());
      run_clocks("after_reset", 240, -1, -1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
